// File: rtl/dequantize.sv
// INT4 -> INT18 dequantizer: reads one block of DEPTH vectors from RAM, scales each lane,
// saturates, and streams results through a 2-entry valid/ready output FIFO.
module dequantize #(
   parameter int unsigned LANES = 16,
   parameter int unsigned QW    = 4,
   parameter int unsigned DW    = 18,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_sf_valid,
   input  logic [DW*LANES-1:0] i_sf_data,
   input  logic                i_start,
   output logic                o_ram_re,
   output logic [AW-1:0]       o_ram_addr,
   input  logic [QW*LANES-1:0] i_ram_data,
   output logic [DW*LANES-1:0] o_data,
   output logic                o_valid,
   input  logic                i_ready,
   output logic                o_busy,
   output logic                o_done
);

   localparam int unsigned PW = QW + DW + 1;
   localparam logic signed [PW-1:0] SAT_MAX = PW'(2**(DW-1) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t               r_state, w_state_nxt;
   logic [AW-1:0]        r_addr, w_addr_nxt;
   logic                 r_inflight;
   logic [1:0]           r_count;
   logic [DW*LANES-1:0]  r_head, r_tail;
   logic [DW*LANES-1:0]  r_sf_act, r_sf_pend;
   logic                 r_sf_pend_vld;
   logic                 r_done;
   logic                 w_issue, w_done_nxt, w_pop, w_push;
   logic [1:0]           w_occ;
   logic signed [PW-1:0] w_prod [LANES];
   logic [DW*LANES-1:0]  w_sat;

   assign w_pop  = (r_count != 2'd0) && i_ready;
   assign w_push = r_inflight;
   // FIFO occupancy once this cycle's pop and returning read have landed
   assign w_occ  = r_count - 2'(w_pop) + 2'(r_inflight);

   // Next-state and read-issue decision
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_issue     = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_RUN;
               w_addr_nxt  = '0;
            end
         end
         S_RUN: begin
            if (w_occ < 2'd2) begin
               w_issue    = 1'b1;
               w_addr_nxt = r_addr + AW'(1);
               if (r_addr == AW'(DEPTH-1)) w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_occ == 2'd0) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Per-lane signed multiply by zero-extended scale factor, then INT18 saturation
   always_comb begin
      w_sat = '0;
      for (int g = 0; g < LANES; g++) begin
         w_prod[g] = PW'($signed(i_ram_data[g*QW +: QW])) *
                     PW'($signed({1'b0, r_sf_act[g*DW +: DW]}));
         if (w_prod[g] > SAT_MAX)      w_sat[g*DW +: DW] = SAT_MAX[DW-1:0];
         else if (w_prod[g] < SAT_MIN) w_sat[g*DW +: DW] = SAT_MIN[DW-1:0];
         else                          w_sat[g*DW +: DW] = w_prod[g][DW-1:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_addr        <= '0;
         r_inflight    <= 1'b0;
         r_count       <= 2'd0;
         r_head        <= '0;
         r_tail        <= '0;
         r_sf_act      <= '0;
         r_sf_pend     <= '0;
         r_sf_pend_vld <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_addr     <= w_addr_nxt;
         r_inflight <= w_issue;
         r_done     <= w_done_nxt;

         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= w_sat;
               else                 r_tail <= w_sat;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_head <= w_sat;
               end else begin
                  r_head <= r_tail;
                  r_tail <= w_sat;
               end
            end
            default: ;
         endcase

         // Scale factors arriving mid-block wait until the block completes
         if (r_done && r_sf_pend_vld) begin
            r_sf_act      <= r_sf_pend;
            r_sf_pend_vld <= 1'b0;
         end
         if (i_sf_valid) begin
            if (r_state == S_IDLE) begin
               r_sf_act <= i_sf_data;
            end else begin
               r_sf_pend     <= i_sf_data;
               r_sf_pend_vld <= 1'b1;
            end
         end
      end
   end

   assign o_ram_re   = w_issue;
   assign o_ram_addr = r_addr;
   assign o_data     = r_head;
   assign o_valid    = (r_count != 2'd0);
   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = r_done;

endmodule

// File: tb/tb_dequantize.sv
// Directed self-checking bench for dequantize: RAM responder with 1-cycle latency,
// per-beat data checks against hand-built expectations, control and timing corners.
module tb_dequantize;

   localparam int unsigned LANES = 16;
   localparam int unsigned QW    = 4;
   localparam int unsigned DW    = 18;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;
   localparam int unsigned W     = DW*LANES;

   logic               clk;
   logic               i_rst_n;
   logic               i_sf_valid;
   logic [W-1:0]       i_sf_data;
   logic               i_start;
   logic               o_ram_re;
   logic [AW-1:0]      o_ram_addr;
   logic [QW*LANES-1:0] i_ram_data;
   logic [W-1:0]       o_data;
   logic               o_valid;
   logic               i_ready;
   logic               o_busy;
   logic               o_done;

   int n_chk  = 0;
   int n_fail = 0;
   int pat_cur = 0;
   logic [W-1:0] beat0, beat1;

   dequantize #(.LANES(LANES), .QW(QW), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_sf_valid(i_sf_valid), .i_sf_data(i_sf_data),
      .i_start(i_start), .o_ram_re(o_ram_re), .o_ram_addr(o_ram_addr),
      .i_ram_data(i_ram_data), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_busy(o_busy), .o_done(o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [QW-1:0] qval(input int pat, input int k, input int g);
      int v;
      if (pat == 0) v = ((k + g) % 16) - 8;
      else          v = (k % 2 == 0) ? 7 : -8;
      return QW'(v);
   endfunction

   function automatic logic [QW*LANES-1:0] ram_word(input int pat, input int k);
      logic [QW*LANES-1:0] r;
      for (int g = 0; g < LANES; g++) r[g*QW +: QW] = qval(pat, k, g);
      return r;
   endfunction

   function automatic logic [W-1:0] exp_vec(input int pat, input int k, input logic [W-1:0] sf);
      logic [W-1:0] r;
      longint p;
      for (int g = 0; g < LANES; g++) begin
         p = longint'($signed(qval(pat, k, g))) * longint'(sf[g*DW +: DW]);
         if (p > 131071)  p = 131071;
         if (p < -131072) p = -131072;
         r[g*DW +: DW] = DW'(p);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] sf_all(input int v);
      logic [W-1:0] r;
      for (int g = 0; g < LANES; g++) r[g*DW +: DW] = DW'(v);
      return r;
   endfunction

   // 1-cycle latency RAM
   initial i_ram_data = '0;
   always @(posedge clk) if (o_ram_re) i_ram_data <= ram_word(pat_cur, int'(o_ram_addr));

   task automatic chk_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_block(input string name, input int pat, input logic [W-1:0] sf_use,
                            input bit sf_with_start, input int ready_pct,
                            input int sf_mid_beat, input logic [W-1:0] sf_mid_data,
                            input int start_mid_beat, input int abort_beat);
      int beats = 0, cyc = 0, done_cnt = 0, done_cyc = -1, first_valid = -1;
      int issued = 0, max_outst = 0, addr_err = 0, stall_err = 0, bad = 0;
      bit stalled = 0, sf_sent = 0, st_sent = 0;
      logic [W-1:0] held = '0;
      pat_cur = pat;
      @(negedge clk);
      i_start = 1'b1;
      i_ready = 1'b1;
      if (sf_with_start) begin
         i_sf_valid = 1'b1;
         i_sf_data  = sf_use;
      end
      @(negedge clk);
      while (cyc < 3000) begin
         i_start    = 1'b0;
         i_sf_valid = 1'b0;
         if (stalled && (o_valid !== 1'b1 || o_data !== held)) stall_err++;
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (o_valid && first_valid < 0) first_valid = cyc;
         if (abort_beat >= 0 && beats == abort_beat) begin
            i_rst_n = 1'b0;
            i_ready = 1'b1;
            @(negedge clk);
            chk_vec({name, "_reset_outputs"},
                    W'({o_ram_re, o_valid, o_busy, o_done, o_ram_addr, o_data}), '0);
            i_rst_n = 1'b1;
            for (int i = 0; i < 80; i++) begin
               @(negedge clk);
               if (o_valid || o_done || o_ram_re) bad++;
            end
            chk_int({name, "_quiet_after_abort"}, bad, 0);
            chk_int({name, "_done_before_abort"}, done_cnt, 0);
            return;
         end
         if (beats == sf_mid_beat && !sf_sent) begin
            i_sf_valid = 1'b1;
            i_sf_data  = sf_mid_data;
            sf_sent    = 1;
         end
         if (beats == start_mid_beat && !st_sent) begin
            i_start = 1'b1;
            st_sent = 1;
         end
         i_ready = (int'($urandom_range(0, 99)) < ready_pct);
         #1;
         if (issued - beats > max_outst) max_outst = issued - beats;
         if (o_ram_re) begin
            if (int'(o_ram_addr) != issued) addr_err++;
            issued++;
         end
         if (o_valid && i_ready) begin
            chk_vec($sformatf("%s_beat%0d", name, beats), o_data, exp_vec(pat, beats, sf_use));
            if (beats == 0) beat0 = o_data;
            if (beats == 1) beat1 = o_data;
            beats++;
         end
         stalled = o_valid && !i_ready;
         held    = o_data;
         if (done_cnt > 0 && cyc >= done_cyc + 4) break;
         @(negedge clk);
         cyc++;
      end
      i_start = 1'b0;
      i_sf_valid = 1'b0;
      chk_int({name, "_beats"}, beats, DEPTH);
      chk_int({name, "_reads"}, issued, DEPTH);
      chk_int({name, "_done_pulses"}, done_cnt, 1);
      chk_int({name, "_addr_order_errs"}, addr_err, 0);
      chk_int({name, "_stall_errs"}, stall_err, 0);
      n_chk++;
      assert (max_outst <= 2) else begin
         n_fail++;
         $error("FAIL %s_outstanding: observed %0d expected <= 2", name, max_outst);
      end
      if (ready_pct == 100) begin
         chk_int({name, "_first_valid_cyc"}, first_valid, 2);
         chk_int({name, "_done_cyc"}, done_cyc, DEPTH + 2);
      end
   endtask

   initial begin
      logic [W-1:0] sf2;
      i_rst_n = 1'b0; i_sf_valid = 1'b0; i_sf_data = '0; i_start = 1'b0; i_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk_vec("reset_outputs", W'({o_ram_re, o_valid, o_busy, o_done, o_ram_addr, o_data}), '0);
      i_rst_n = 1'b1;
      @(negedge clk);

      // Round trip, sf loaded together with start
      run_block("rt", 0, sf_all(18432), 1, 100, -1, '0, -1, -1);
      chk_int("rt_b0_l0", int'($signed(beat0[0 +: DW])), -131072);
      chk_int("rt_b0_l1", int'($signed(beat0[DW +: DW])), -129024);
      chk_int("rt_b0_l15", int'($signed(beat0[15*DW +: DW])), 129024);

      // Zero, unit and full-scale factors
      sf2 = sf_all(100);
      sf2[0 +: DW] = DW'(0);
      sf2[DW +: DW] = DW'(1);
      sf2[15*DW +: DW] = DW'(131071);
      @(negedge clk);
      i_sf_valid = 1'b1; i_sf_data = sf2;
      @(negedge clk);
      i_sf_valid = 1'b0;
      run_block("small", 1, sf2, 0, 100, -1, '0, -1, -1);
      chk_int("small_b0_l0", int'($signed(beat0[0 +: DW])), 0);
      chk_int("small_b0_l1", int'($signed(beat0[DW +: DW])), 7);
      chk_int("small_b1_l1", int'($signed(beat1[DW +: DW])), -8);
      chk_int("small_b0_l15", int'($signed(beat0[15*DW +: DW])), 131071);
      chk_int("small_b1_l15", int'($signed(beat1[15*DW +: DW])), -131072);

      // Backpressure with ready at 30%
      sf2 = '0;
      for (int g = 0; g < LANES; g++) sf2[g*DW +: DW] = DW'(1000*g + 1);
      run_block("bp", 0, sf2, 1, 30, -1, '0, -1, -1);

      // Scale factor arriving mid-block takes effect on the following block
      run_block("sfmid_a", 0, sf_all(3), 1, 100, 20, sf_all(5), -1, -1);
      chk_int("sfmid_a_b0_l3", int'($signed(beat0[3*DW +: DW])), -15);
      run_block("sfmid_b", 0, sf_all(5), 0, 100, -1, '0, -1, -1);
      chk_int("sfmid_b_b0_l3", int'($signed(beat0[3*DW +: DW])), -25);

      // Start during a running block is ignored
      run_block("restart", 1, sf_all(5), 0, 100, -1, '0, 10, -1);

      // Reset at beat 30 aborts, scale factors are cleared, then a fresh block runs
      run_block("abort", 0, sf_all(7), 1, 100, -1, '0, -1, 30);
      run_block("post_rst_zero_sf", 0, '0, 0, 100, -1, '0, -1, -1);
      run_block("fresh", 0, sf_all(2), 1, 100, -1, '0, -1, -1);
      chk_int("fresh_b0_l0", int'($signed(beat0[0 +: DW])), -16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
